// File: rtl/redun_mont_pkg.sv
// rtl/redun_mont_pkg.sv - shared constants, types and full-width reference conversion for redundant Montgomery form
package redun_mont_pkg;

    localparam int RM_WRD_BITS = 32;
    localparam int RM_NUM_WRDS = 33;
    localparam int RM_DAT_BITS = RM_NUM_WRDS * RM_WRD_BITS;
    localparam int RM_RED_BITS = RM_NUM_WRDS * (RM_WRD_BITS + 1);

    typedef logic [RM_WRD_BITS:0]   redun_wrd_t;
    typedef logic [RM_RED_BITS-1:0] redun0_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } rcr_state_t;

    localparam logic [RM_DAT_BITS-1:0] P = {32'hE3B0_C442, {31{32'h98FC_1C14}}, 32'h9AFB_F4C9};

    // Returns {overflow, value}: overflow is set when the sum does not fit in RM_DAT_BITS.
    function automatic logic [RM_DAT_BITS:0] from_redun_ovf(input redun0_t x);
        logic [RM_DAT_BITS+1:0] acc;
        acc = '0;
        for (int i = 0; i < RM_NUM_WRDS; i++) begin
            acc += (RM_DAT_BITS+2)'(x[i*(RM_WRD_BITS+1) +: RM_WRD_BITS+1]) << (i*RM_WRD_BITS);
        end
        return {|acc[RM_DAT_BITS+1:RM_DAT_BITS], acc[RM_DAT_BITS-1:0]};
    endfunction

endpackage

// File: rtl/redun_resolve_slice.sv
// rtl/redun_resolve_slice.sv - combinational carry and borrow chains across one beat of redundant words
module redun_resolve_slice
    import redun_mont_pkg::*;
#(
    parameter int WRD_BITS = RM_WRD_BITS,
    parameter int NUM      = 3
) (
    input  logic [1:0]                  i_carry,
    input  logic                        i_borrow,
    input  logic [NUM*(WRD_BITS+1)-1:0] i_wrds,
    input  logic [NUM*WRD_BITS-1:0]     i_p_wrds,
    output logic [NUM*WRD_BITS-1:0]     o_res,
    output logic [NUM*WRD_BITS-1:0]     o_sub,
    output logic [1:0]                  o_carry,
    output logic                        o_borrow
);

    logic [1:0]          c;
    logic                b;
    logic [WRD_BITS+1:0] s;
    logic [WRD_BITS-1:0] r;
    logic [WRD_BITS:0]   d;

    always_comb begin
        c     = i_carry;
        b     = i_borrow;
        s     = '0;
        r     = '0;
        d     = '0;
        o_res = '0;
        o_sub = '0;
        for (int k = 0; k < NUM; k++) begin
            s = {1'b0, i_wrds[k*(WRD_BITS+1) +: WRD_BITS+1]} + {{WRD_BITS{1'b0}}, c};
            r = s[WRD_BITS-1:0];
            // The borrow chain subtracts P from the already-resolved word of this position.
            d = {1'b0, r} - {1'b0, i_p_wrds[k*WRD_BITS +: WRD_BITS]} - {{WRD_BITS{1'b0}}, b};
            o_res[k*WRD_BITS +: WRD_BITS] = r;
            o_sub[k*WRD_BITS +: WRD_BITS] = d[WRD_BITS-1:0];
            c = s[WRD_BITS+1:WRD_BITS];
            b = d[WRD_BITS];
        end
        o_carry  = c;
        o_borrow = b;
    end

endmodule

// File: rtl/redun_carry_resolve.sv
// rtl/redun_carry_resolve.sv - word-serial redundant-to-binary converter with optional fold of one P subtraction
module redun_carry_resolve
    import redun_mont_pkg::*;
#(
    parameter int WRD_BITS     = RM_WRD_BITS,
    parameter int NUM_WRDS     = RM_NUM_WRDS,
    parameter int WRDS_PER_CYC = 3,
    parameter logic [NUM_WRDS*WRD_BITS-1:0] P = redun_mont_pkg::P
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0] i_dat,
    input  logic                            i_sub_p,
    input  logic                            i_val,
    output logic                            o_rdy,
    output logic [NUM_WRDS*WRD_BITS-1:0]    o_dat,
    output logic                            o_ovf,
    output logic                            o_val,
    input  logic                            i_rdy
);

    localparam int DAT_BITS = NUM_WRDS * WRD_BITS;
    localparam int NUM_CYC  = (NUM_WRDS + WRDS_PER_CYC - 1) / WRDS_PER_CYC;
    localparam int PAD_WRDS = NUM_CYC * WRDS_PER_CYC;
    localparam int IN_W     = PAD_WRDS * (WRD_BITS + 1);
    localparam int CH_IN    = WRDS_PER_CYC * (WRD_BITS + 1);
    localparam int OUT_W    = PAD_WRDS * WRD_BITS;
    localparam int CH_OUT   = WRDS_PER_CYC * WRD_BITS;
    localparam int CNT_W    = $clog2(NUM_CYC + 1);
    localparam logic [OUT_W-1:0] P_PAD = OUT_W'(P);

    rcr_state_t       state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [1:0]       carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             sub_p_q, sub_p_d;
    logic [IN_W-1:0]  dat_q, dat_d;
    logic [OUT_W-1:0] res_q, res_d;
    logic [OUT_W-1:0] sub_q, sub_d;

    logic [CH_OUT-1:0] slc_res, slc_sub;
    logic [1:0]        slc_carry;
    logic              slc_borrow;
    logic              fin_carry;
    logic              use_sub;

    redun_resolve_slice #(
        .WRD_BITS (WRD_BITS),
        .NUM      (WRDS_PER_CYC)
    ) u_slice (
        .i_carry  (carry_q),
        .i_borrow (borrow_q),
        .i_wrds   (dat_q[CH_IN-1:0]),
        .i_p_wrds (P_PAD[int'(beat_q)*CH_OUT +: CH_OUT]),
        .o_res    (slc_res),
        .o_sub    (slc_sub),
        .o_carry  (slc_carry),
        .o_borrow (slc_borrow)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            carry_q  <= '0;
            borrow_q <= 1'b0;
            sub_p_q  <= 1'b0;
            dat_q    <= '0;
            res_q    <= '0;
            sub_q    <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            sub_p_q  <= sub_p_d;
            dat_q    <= dat_d;
            res_q    <= res_d;
            sub_q    <= sub_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        sub_p_d  = sub_p_q;
        dat_d    = dat_q;
        res_d    = res_q;
        sub_d    = sub_q;
        case (state_q)
            ST_IDLE: begin
                if (i_val) begin
                    dat_d    = IN_W'(i_dat);
                    sub_p_d  = i_sub_p;
                    carry_d  = '0;
                    borrow_d = 1'b0;
                    beat_d   = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Results enter at the top so word 0 lands at the bottom after the last beat.
                dat_d    = dat_q >> CH_IN;
                res_d    = (res_q >> CH_OUT) | (OUT_W'(slc_res) << (OUT_W - CH_OUT));
                sub_d    = (sub_q >> CH_OUT) | (OUT_W'(slc_sub) << (OUT_W - CH_OUT));
                carry_d  = slc_carry;
                borrow_d = slc_borrow;
                if (beat_q == CNT_W'(NUM_CYC - 1)) begin
                    beat_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (i_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A carry out of the top real word lands in the first padding word when padding exists.
    assign fin_carry = (carry_q != 2'd0) || (|(res_q >> DAT_BITS));
    assign use_sub   = sub_p_q && (fin_carry || !borrow_q);

    assign o_rdy = (state_q == ST_IDLE);
    assign o_val = (state_q == ST_DONE);
    assign o_ovf = fin_carry;
    assign o_dat = use_sub ? sub_q[DAT_BITS-1:0] : res_q[DAT_BITS-1:0];

endmodule

// File: tb/tb_redun_carry_resolve.sv
// tb/tb_redun_carry_resolve.sv - directed-vector and randomized checks of redun_carry_resolve
module tb_redun_carry_resolve;
    import redun_mont_pkg::*;

    localparam int DAT = RM_DAT_BITS;

    logic           clk = 1'b0;
    logic           rst;
    redun0_t        dat_a, dat_b;
    logic           sub_a, sub_b, val_a, val_b, irdy_a, irdy_b;
    logic           rdy_a, rdy_b, ovf_a, ovf_b, oval_a, oval_b;
    logic [DAT-1:0] odat_a, odat_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    redun_carry_resolve u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_dat(dat_a), .i_sub_p(sub_a), .i_val(val_a),
        .o_rdy(rdy_a), .o_dat(odat_a), .o_ovf(ovf_a), .o_val(oval_a), .i_rdy(irdy_a)
    );

    redun_carry_resolve #(.WRDS_PER_CYC(4)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_dat(dat_b), .i_sub_p(sub_b), .i_val(val_b),
        .o_rdy(rdy_b), .o_dat(odat_b), .o_ovf(ovf_b), .o_val(oval_b), .i_rdy(irdy_b)
    );

    typedef struct {
        redun0_t        dat;
        logic           sub_p;
        logic [DAT-1:0] exp_dat;
        logic           exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [DAT-1:0] got, input logic [DAT-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ..%h want ..%h", nm, got[127:0], exp[127:0]);
        end
    endtask

    function automatic redun0_t to_redun(input logic [DAT-1:0] v);
        redun0_t r;
        r = '0;
        for (int i = 0; i < RM_NUM_WRDS; i++) r[i*33 +: 33] = {1'b0, v[i*32 +: 32]};
        return r;
    endfunction

    function automatic logic [DAT:0] model(input redun0_t d, input logic s);
        logic [DAT:0]   m;
        logic [DAT-1:0] v;
        m = from_redun_ovf(d);
        v = m[DAT-1:0];
        if (s && (m[DAT] || v >= P)) v = v - P;
        return {m[DAT], v};
    endfunction

    task automatic run_a(input redun0_t d, input logic s, output int lat);
        int n;
        n = 0;
        dat_a = d; sub_a = s; val_a = 1'b1;
        while (!rdy_a && n < 50) begin step(); n++; end
        step();
        val_a = 1'b0;
        lat = 1;
        while (!oval_a && lat < 100) begin step(); lat++; end
    endtask

    initial begin : main
        redun0_t        d;
        logic           s;
        logic [DAT:0]   m;
        logic [DAT-1:0] all1, negp;
        logic [32:0]    w;
        int             lat, seen, n;

        rst = 1'b1;
        dat_a = '0; sub_a = 1'b0; val_a = 1'b0; irdy_a = 1'b1;
        dat_b = '0; sub_b = 1'b0; val_b = 1'b0; irdy_b = 1'b0;
        all1 = '1;
        negp = '0 - P;

        d = '0; d[0 +: 33] = 33'h1_0000_0000;
        vecs[0] = '{d, 1'b0, DAT'(1) << 32, 1'b0};
        for (int i = 1; i < RM_NUM_WRDS; i++) d[i*33 +: 33] = 33'h0_FFFF_FFFF;
        vecs[1] = '{d, 1'b0, '0, 1'b1};
        vecs[7] = '{d, 1'b1, negp, 1'b1};
        vecs[2] = '{to_redun(P), 1'b1, '0, 1'b0};
        vecs[3] = '{to_redun(P - 1), 1'b1, P - 1, 1'b0};
        d = to_redun(P + 5);
        d[0 +: 33]  = d[0 +: 33] + 33'h1_0000_0000;
        d[33 +: 33] = d[33 +: 33] - 33'd1;
        vecs[4] = '{d, 1'b1, DAT'(5), 1'b0};
        vecs[5] = '{to_redun('0), 1'b1, '0, 1'b0};
        vecs[6] = '{to_redun(all1), 1'b1, all1 - P, 1'b0};

        repeat (3) step();
        chk("rst_rdy", DAT'(rdy_a), DAT'(1));
        chk("rst_val", DAT'(oval_a), DAT'(0));
        chk("rst_dat", odat_a, '0);
        chk("rst_ovf", DAT'(ovf_a), DAT'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_a(vecs[i].dat, vecs[i].sub_p, lat);
            chk($sformatf("v%0d_lat", i), DAT'(lat), DAT'(12));
            chk($sformatf("v%0d_dat", i), odat_a, vecs[i].exp_dat);
            chk($sformatf("v%0d_ovf", i), DAT'(ovf_a), DAT'(vecs[i].exp_ovf));
            step();
            chk($sformatf("v%0d_rdy_after", i), DAT'(rdy_a), DAT'(1));
        end

        // Downstream stall: result must hold while extra i_val pulses are ignored.
        irdy_a = 1'b0;
        run_a(vecs[4].dat, 1'b1, lat);
        for (int k = 0; k < 5; k++) begin
            val_a = k[0]; dat_a = to_redun(all1); sub_a = 1'b0;
            step();
            chk($sformatf("stall%0d_val", k), DAT'(oval_a), DAT'(1));
            chk($sformatf("stall%0d_rdy", k), DAT'(rdy_a), DAT'(0));
            chk($sformatf("stall%0d_dat", k), odat_a, DAT'(5));
            chk($sformatf("stall%0d_ovf", k), DAT'(ovf_a), DAT'(0));
        end
        val_a = 1'b0; irdy_a = 1'b1;
        step();
        chk("stall_rel_rdy", DAT'(rdy_a), DAT'(1));
        chk("stall_rel_val", DAT'(oval_a), DAT'(0));

        // Reset mid-RUN discards the pending result.
        dat_a = vecs[1].dat; sub_a = 1'b0; val_a = 1'b1;
        step();
        val_a = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_rdy", DAT'(rdy_a), DAT'(1));
        seen = 0;
        repeat (15) begin step(); if (oval_a) seen = 1; end
        chk("midrst_noval", DAT'(seen), DAT'(0));
        d = vecs[6].dat; d[5*33 +: 33] = 33'h1_2345_6789;
        m = model(d, 1'b1);
        run_a(d, 1'b1, lat);
        chk("postrst_lat", DAT'(lat), DAT'(12));
        chk("postrst_dat", odat_a, m[DAT-1:0]);
        chk("postrst_ovf", DAT'(ovf_a), DAT'(m[DAT]));
        step();

        // Padded configuration: random redundant inputs with random downstream stalls.
        for (int t = 0; t < 1000; t++) begin
            for (int i = 0; i < RM_NUM_WRDS; i++) begin
                w[31:0] = $urandom();
                w[32]   = 1'($urandom_range(0, 1));
                d[i*33 +: 33] = w;
            end
            if ($urandom_range(0, 7) == 0) d = to_redun(P + DAT'($urandom_range(0, 2)) - DAT'(1));
            s = 1'($urandom_range(0, 1));
            m = model(d, s);
            dat_b = d; sub_b = s; val_b = 1'b1; irdy_b = 1'b0;
            n = 0;
            while (!rdy_b && n < 50) begin step(); n++; end
            step();
            val_b = 1'b0;
            n = 0;
            while (!oval_b && n < 100) begin step(); n++; end
            repeat ($urandom_range(0, 3)) step();
            chk($sformatf("rnd%0d_val", t), DAT'(oval_b), DAT'(1));
            chk($sformatf("rnd%0d_dat", t), odat_b, m[DAT-1:0]);
            chk($sformatf("rnd%0d_ovf", t), DAT'(ovf_b), DAT'(m[DAT]));
            irdy_b = 1'b1;
            step();
            irdy_b = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "time limit");
    end

endmodule
